// File: rtl/qspi_flash_rd_sequencer_pkg.sv
// Shared types, SPIM opcodes and command-word builder for the flash read sequencer.
package qspi_seq_pkg;

  localparam int unsigned IDX_W  = 2;
  localparam int unsigned WORD_W = 32;

  // SPIM command opcodes, placed in word bits [31:28]
  localparam logic [3:0] SPIM_CFG       = 4'h0;
  localparam logic [3:0] SPIM_SOT       = 4'h1;
  localparam logic [3:0] SPIM_SEND_CMD  = 4'h2;
  localparam logic [3:0] SPIM_SEND_ADDR = 4'h3;
  localparam logic [3:0] SPIM_DUMMY     = 4'h4;
  localparam logic [3:0] SPIM_RX_DATA   = 4'h7;
  localparam logic [3:0] SPIM_EOT       = 4'h9;

  // Position of each word in the emitted stream
  localparam logic [2:0] SLOT_CFG      = 3'd0;
  localparam logic [2:0] SLOT_SOT      = 3'd1;
  localparam logic [2:0] SLOT_CMD      = 3'd2;
  localparam logic [2:0] SLOT_ADDR     = 3'd3;
  localparam logic [2:0] SLOT_ADDR_VAL = 3'd4;
  localparam logic [2:0] SLOT_DUMMY    = 3'd5;
  localparam logic [2:0] SLOT_RX       = 3'd6;
  localparam logic [2:0] SLOT_EOT      = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EMIT     = 2'd1,
    ST_WAIT_EOT = 2'd2
  } qspi_seq_state_e;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] len;
    logic [1:0]  csn;
    logic        quad;
  } qspi_rd_req_t;

  typedef struct packed {
    logic [7:0]  clkdiv;
    logic [7:0]  opcode;
    logic [4:0]  dummy;
    logic [15:0] timeout;
  } qspi_rd_cfg_t;

  // Command word for a given stream slot
  function automatic logic [WORD_W-1:0] spim_word(input logic [2:0] slot,
                                                  input qspi_rd_req_t r,
                                                  input qspi_rd_cfg_t c);
    logic [WORD_W-1:0] w;
    w = '0;
    case (slot)
      SLOT_CFG:      w = {SPIM_CFG, 20'h0, c.clkdiv};
      SLOT_SOT:      w = {SPIM_SOT, 26'h0, r.csn};
      SLOT_CMD:      w = {SPIM_SEND_CMD, r.quad, 7'h0, 4'd7, 8'h0, c.opcode};
      SLOT_ADDR:     w = {SPIM_SEND_ADDR, r.quad, 6'h0, 5'd23, 16'h0};
      SLOT_ADDR_VAL: w = {8'h00, r.addr};
      SLOT_DUMMY:    w = {SPIM_DUMMY, 7'h0, 5'(c.dummy - 5'd1), 16'h0};
      SLOT_RX:       w = {SPIM_RX_DATA, r.quad, 11'h0, 16'(r.len - 16'd1)};
      default:       w = {SPIM_EOT, 27'h0, 1'b1};
    endcase
    return w;
  endfunction

  // Following slot; the DUMMY word is skipped when no dummy cycles are set
  function automatic logic [2:0] next_slot(input logic [2:0] slot, input logic [4:0] dummy);
    if (slot == SLOT_ADDR_VAL && dummy == 5'd0) return SLOT_RX;
    return 3'(slot + 3'd1);
  endfunction

endpackage

// File: rtl/qspi_flash_rd_sequencer_if.sv
// Requester, configuration and SPIM command-channel signals of the sequencer.
interface qspi_flash_rd_sequencer_if #(
  parameter int unsigned NUM_REQ = 2
);
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ-1:0][23:0] req_addr_i;
  logic [NUM_REQ-1:0][15:0] req_len_i;
  logic [NUM_REQ-1:0][1:0]  req_csn_i;
  logic [NUM_REQ-1:0]       req_quad_i;
  logic [NUM_REQ-1:0]       done_o;
  logic [7:0]               cfg_clkdiv_i;
  logic [7:0]               cfg_opcode_i;
  logic [4:0]               cfg_dummy_i;
  logic [15:0]              cfg_timeout_i;
  logic [31:0]              cmd_data_o;
  logic                     cmd_valid_o;
  logic                     cmd_ready_i;
  logic                     spi_eot_i;
  logic                     busy_o;
  logic [1:0]               owner_o;
  logic                     err_o;

  // Sequencer side
  modport slave (
    input  req_valid_i, req_addr_i, req_len_i, req_csn_i, req_quad_i,
    input  cfg_clkdiv_i, cfg_opcode_i, cfg_dummy_i, cfg_timeout_i,
    input  cmd_ready_i, spi_eot_i,
    output req_ready_o, done_o, cmd_data_o, cmd_valid_o, busy_o, owner_o, err_o
  );

  // Requester / SPIM side
  modport master (
    output req_valid_i, req_addr_i, req_len_i, req_csn_i, req_quad_i,
    output cfg_clkdiv_i, cfg_opcode_i, cfg_dummy_i, cfg_timeout_i,
    output cmd_ready_i, spi_eot_i,
    input  req_ready_o, done_o, cmd_data_o, cmd_valid_o, busy_o, owner_o, err_o
  );
endinterface

// File: rtl/qspi_flash_rd_sequencer_rr_arbiter.sv
// Round-robin pick of the first valid requester at or after an externally held pointer.
module qspi_seq_rr_arbiter
  import qspi_seq_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [3:0]       req_pad;
  logic [IDX_W-1:0] cand;

  assign req_pad = 4'(req);

  // Scan from ptr with wrap; lowest offset wins
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!gnt_valid && req_pad[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/qspi_flash_rd_sequencer.sv
// Arbitrates flash-read requests and streams the SPIM command words for each grant.
module qspi_flash_rd_sequencer
  import qspi_seq_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input logic                       sys_clk_i,
  input logic                       rst_i,
  qspi_flash_rd_sequencer_if.slave  bus
);

  localparam logic [1:0] IDLE     = ST_IDLE;
  localparam logic [1:0] EMIT     = ST_EMIT;
  localparam logic [1:0] WAIT_EOT = ST_WAIT_EOT;

  logic [1:0]        state_q, state_d;
  logic [2:0]        slot_q, slot_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  qspi_rd_req_t      req_q, req_d, req_sel;
  qspi_rd_cfg_t      cfg_q, cfg_d, cfg_in;
  logic [15:0]       wd_q, wd_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [WORD_W-1:0] cmd_data_q, cmd_data_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [NUM_REQ-1:0] grant_oh, owner_oh;
  logic              err_q, err_d;
  logic              busy_q;
  logic              gnt_valid;
  logic [IDX_W-1:0]  gnt_idx;
  logic              take;

  qspi_seq_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (bus.req_valid_i),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign take   = (state_q == IDLE) && gnt_valid && !rst_i;
  assign cfg_in = '{clkdiv:  bus.cfg_clkdiv_i,
                    opcode:  bus.cfg_opcode_i,
                    dummy:   bus.cfg_dummy_i,
                    timeout: bus.cfg_timeout_i};

  // Select the granted requester's payload and build one-hot grant/owner vectors
  always_comb begin
    req_sel  = '0;
    grant_oh = '0;
    owner_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      owner_oh[i] = (owner_q == IDX_W'(i));
      if (gnt_idx == IDX_W'(i)) begin
        req_sel.addr = bus.req_addr_i[i];
        req_sel.len  = bus.req_len_i[i];
        req_sel.csn  = bus.req_csn_i[i];
        req_sel.quad = bus.req_quad_i[i];
        grant_oh[i]  = take;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    req_d       = req_q;
    cfg_d       = cfg_q;
    wd_d        = wd_q;
    cmd_valid_d = cmd_valid_q;
    cmd_data_d  = cmd_data_q;
    done_d      = '0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) begin
          rr_ptr_d = IDX_W'((32'(gnt_idx) + 32'd1) % NUM_REQ);
          owner_d  = gnt_idx;
          req_d    = req_sel;
          cfg_d    = cfg_in;
          if (req_sel.len == 16'd0) begin
            done_d = grant_oh;
          end else begin
            state_d     = EMIT;
            slot_d      = SLOT_CFG;
            cmd_valid_d = 1'b1;
            cmd_data_d  = spim_word(SLOT_CFG, req_sel, cfg_in);
          end
        end
      end
      EMIT: begin
        if (bus.cmd_ready_i) begin
          if (slot_q == SLOT_EOT) begin
            state_d     = WAIT_EOT;
            cmd_valid_d = 1'b0;
            cmd_data_d  = '0;
            wd_d        = '0;
          end else begin
            slot_d     = next_slot(slot_q, cfg_q.dummy);
            cmd_data_d = spim_word(slot_d, req_q, cfg_q);
          end
        end
      end
      WAIT_EOT: begin
        if (bus.spi_eot_i) begin
          state_d = IDLE;
          done_d  = owner_oh;
        end else if (cfg_q.timeout != 16'd0 && wd_q == 16'(cfg_q.timeout - 16'd1)) begin
          state_d = IDLE;
          done_d  = owner_oh;
          err_d   = 1'b1;
        end else if (wd_q != 16'hFFFF) begin
          wd_d = 16'(wd_q + 16'd1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      slot_q      <= SLOT_CFG;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      req_q       <= '0;
      cfg_q       <= '0;
      wd_q        <= '0;
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      req_q       <= req_d;
      cfg_q       <= cfg_d;
      wd_q        <= wd_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_data_q  <= cmd_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.req_ready_o = grant_oh;
  assign bus.done_o      = done_q;
  assign bus.cmd_valid_o = cmd_valid_q;
  assign bus.cmd_data_o  = cmd_data_q;
  assign bus.busy_o      = busy_q;
  assign bus.owner_o     = owner_q;
  assign bus.err_o       = err_q;

endmodule
